lcd_cmd_seq: RTL and testbench

- Host-side sequencer directly upstream of the 6x6 LCD window controller.
- Buffers host commands in a small FIFO and issues them one at a time on the controller's cmd/cmd_valid/datain interface, obeying its busy handshake.
- On a Load command, streams the 36-pixel image from a synchronous pixel ROM.
- Counts 9-pixel output frames coming back from the controller.

---
 rtl/lcd_cmd_seq.sv | 179 +++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// Host command FIFO and issue sequencer feeding the 6x6 LCD window controller.
// Define LCD_SEQ_TIMEOUT_EN to add the busy watchdog and sticky err_timeout output.
module lcd_cmd_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIX_NUM    = 36
`ifdef LCD_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 255
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [5:0] pix_addr,
    input  logic [7:0] pix_data,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    input  logic       output_valid,
    output logic       frame_done,
    output logic       err_cmd,
`ifdef LCD_SEQ_TIMEOUT_EN
    output logic       err_timeout,
`endif
    output logic       seq_idle
);
    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);
    localparam logic [5:0]  LastPix = 6'(PIX_NUM - 1);
    localparam logic [2:0]  CmdLoad = 3'd1;

    typedef enum logic [2:0] {StIdle, StIssue, StStream, StGuard, StWait} state_e;

    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [2:0]    head;

    state_e        state;
    logic [5:0]    pix_cnt;
    logic [5:0]    pix_addr_q;
    logic [2:0]    cmd_q;
    logic          cmd_valid_q;
    logic          err_cmd_q;
    logic [3:0]    frame_cnt;
`ifdef LCD_SEQ_TIMEOUT_EN
    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);
    logic [7:0]    wdog;
    logic          err_timeout_q;
`endif

    assign full  = (count == FullCnt);
    assign empty = (count == '0);
    assign push  = host_valid && !full && !reset;
    assign pop   = (state == StIdle) && !empty && !busy && !reset;
    assign head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            pix_cnt     <= '0;
            pix_addr_q  <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            err_cmd_q   <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
            wdog          <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= 3'd0;
            err_cmd_q   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        if (head > 3'd5) begin
                            err_cmd_q <= 1'b1;
                        end else begin
                            state       <= StIssue;
                            cmd_valid_q <= 1'b1;
                            cmd_q       <= head;
                            pix_addr_q  <= '0;
                        end
                    end
                end
                StIssue: begin
                    if (cmd_q == CmdLoad) begin
                        state      <= StStream;
                        pix_cnt    <= '0;
                        pix_addr_q <= 6'd1;
                    end else begin
                        state <= StGuard;
                    end
                end
                StStream: begin
                    if (pix_cnt == LastPix) begin
                        state      <= StGuard;
                        pix_addr_q <= '0;
                    end else begin
                        pix_cnt <= pix_cnt + 6'd1;
                        // Address runs one pixel ahead of the ROM output, clamped at the last pixel
                        pix_addr_q <= (pix_cnt + 6'd1 == LastPix) ? LastPix : pix_cnt + 6'd2;
                    end
                end
                StGuard: begin
                    state <= StWait;
`ifdef LCD_SEQ_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                StWait: begin
                    if (!busy) begin
                        state <= StIdle;
`ifdef LCD_SEQ_TIMEOUT_EN
                    end else if (wdog == WdogLast) begin
                        err_timeout_q <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        wdog <= wdog + 8'd1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (output_valid) begin
            frame_cnt <= (frame_cnt == 4'd8) ? 4'd0 : frame_cnt + 4'd1;
        end
    end

    assign host_ready = reset || !full;
    assign seq_idle   = reset || ((state == StIdle) && empty);
    assign cmd        = reset ? 3'd0 : cmd_q;
    assign cmd_valid  = cmd_valid_q && !reset;
    assign err_cmd    = err_cmd_q && !reset;
    assign pix_addr   = reset ? 6'd0 : pix_addr_q;
    assign datain     = (!reset && state == StStream) ? pix_data : 8'd0;
    assign frame_done = !reset && output_valid && (frame_cnt == 4'd8);
`ifdef LCD_SEQ_TIMEOUT_EN
    assign err_timeout = err_timeout_q && !reset;
`endif

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed self-checking bench for lcd_cmd_seq with a pixel ROM and a busy-holding controller model.
module tb_lcd_cmd_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] host_cmd = 3'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [5:0] pix_addr;
    logic [7:0] pix_data;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy;
    logic       output_valid = 1'b0;
    logic       frame_done;
    logic       err_cmd;
    logic       seq_idle;
`ifdef LCD_SEQ_TIMEOUT_EN
    logic       err_timeout;
`endif

    int         comp_cnt = 0;
    int         mism_cnt = 0;
    int         cv_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         cv_cyc = 0;
    int         err_cyc = 0;
    logic [2:0] last_cmd = 3'd0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;

    lcd_cmd_seq dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .busy         (busy),
        .output_valid (output_valid),
        .frame_done   (frame_done),
        .err_cmd      (err_cmd),
`ifdef LCD_SEQ_TIMEOUT_EN
        .err_timeout  (err_timeout),
`endif
        .seq_idle     (seq_idle)
    );

    always #5 clk = ~clk;

    // ROM[i] = i + 10; controller holds busy 45 cycles after Load, 5 after other commands
    assign busy = force_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        pix_data <= 8'(pix_addr) + 8'd10;
        if (cmd_valid) busy_cnt <= (cmd == 3'd1) ? 45 : 5;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cmd_valid) begin
            cv_cnt++;
            cv_cyc   = cyc;
            last_cmd = cmd;
        end
        if (err_cmd) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            tick();
            if (seq_idle) ok = 1'b1;
        end
    endtask

    task automatic wait_cv(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (cmd_valid) ok = 1'b1;
        end
    endtask

    task automatic push(input logic [2:0] code);
        host_cmd   = code;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        comp_cnt++;
        if (cmd_valid !== 1'b0) begin mism_cnt++; $display("FAIL reset_cmd_valid: got %0b want 0", cmd_valid); end
        comp_cnt++;
        if (cmd !== 3'd0) begin mism_cnt++; $display("FAIL reset_cmd: got %0d want 0", cmd); end
        comp_cnt++;
        if (datain !== 8'd0) begin mism_cnt++; $display("FAIL reset_datain: got %0d want 0", datain); end
        comp_cnt++;
        if (pix_addr !== 6'd0) begin mism_cnt++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
        comp_cnt++;
        if (frame_done !== 1'b0 || err_cmd !== 1'b0) begin
            mism_cnt++;
            $display("FAIL reset_pulses: got frame_done=%0b err_cmd=%0b want 0 0", frame_done, err_cmd);
        end
        comp_cnt++;
        if (host_ready !== 1'b1 || seq_idle !== 1'b1) begin
            mism_cnt++;
            $display("FAIL reset_ready_idle: got host_ready=%0b seq_idle=%0b want 1 1", host_ready, seq_idle);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int start;
        bit ok;
        start = cv_cnt;
        push(3'd1);
        wait_cv(ok);
        comp_cnt++;
        if (!ok || cmd !== 3'd1) begin mism_cnt++; $display("FAIL load_issue: got ok=%0b cmd=%0d want 1 1", ok, cmd); end
        for (int k = 0; k < 36; k++) begin
            tick();
            comp_cnt++;
            if (datain !== 8'(k + 10)) begin
                mism_cnt++;
                $display("FAIL load_pixel_%0d: got %0d want %0d", k, datain, k + 10);
            end
        end
        tick();
        comp_cnt++;
        if (datain !== 8'd0) begin mism_cnt++; $display("FAIL load_after_stream: got %0d want 0", datain); end
        wait_idle(ok);
        comp_cnt++;
        if (!ok || busy !== 1'b0 || busy_cnt != 0) begin
            mism_cnt++;
            $display("FAIL load_idle: got ok=%0b busy=%0b want 1 0", ok, busy);
        end
        comp_cnt++;
        if (cv_cnt - start != 1) begin mism_cnt++; $display("FAIL load_cv_count: got %0d want 1", cv_cnt - start); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_cmds [3];
        int got;
        int since_low;
        bit ok;
        exp_cmds[0] = 3'd2;
        exp_cmds[1] = 3'd4;
        exp_cmds[2] = 3'd0;
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            comp_cnt++;
            if (host_ready !== 1'b1) begin mism_cnt++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, host_ready); end
            push(exp_cmds[i]);
        end
        tick();
        force_busy = 1'b0;
        got = 0;
        since_low = 1;
        for (int n = 0; n < 200 && got < 3; n++) begin
            tick();
            if (busy) since_low = 0;
            else since_low++;
            if (cmd_valid) begin
                comp_cnt++;
                if (cmd !== exp_cmds[got]) begin
                    mism_cnt++;
                    $display("FAIL b2b_cmd_%0d: got %0d want %0d", got, cmd, exp_cmds[got]);
                end
                comp_cnt++;
                if (since_low < ((got == 0) ? 2 : 3)) begin
                    mism_cnt++;
                    $display("FAIL b2b_gap_%0d: got %0d low cycles want >= %0d", got, since_low,
                             (got == 0) ? 2 : 3);
                end
                got++;
            end
        end
        comp_cnt++;
        if (got != 3) begin mism_cnt++; $display("FAIL b2b_count: got %0d want 3", got); end
        wait_idle(ok);
    endtask

    task automatic test_fifo_full();
        int start;
        bit ok;
        start = cv_cnt;
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            comp_cnt++;
            if (host_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                mism_cnt++;
                $display("FAIL full_ready_%0d: got %0b want %0b", i, host_ready, (i < 4) ? 1'b1 : 1'b0);
            end
            host_cmd   = 3'd3;
            host_valid = 1'b1;
            tick();
        end
        comp_cnt++;
        if (host_ready !== 1'b0) begin mism_cnt++; $display("FAIL full_held: got %0b want 0", host_ready); end
        host_valid = 1'b0;
        force_busy = 1'b0;
        wait_idle(ok);
        comp_cnt++;
        if (!ok || cv_cnt - start != 4) begin
            mism_cnt++;
            $display("FAIL full_drain: got ok=%0b issued=%0d want 1 4", ok, cv_cnt - start);
        end
    endtask

    task automatic test_illegal();
        int cv0;
        int err0;
        bit ok;
        cv0  = cv_cnt;
        err0 = err_cnt;
        host_cmd   = 3'd7;
        host_valid = 1'b1;
        tick();
        host_cmd = 3'd5;
        tick();
        host_valid = 1'b0;
        wait_idle(ok);
        comp_cnt++;
        if (err_cnt - err0 != 1) begin mism_cnt++; $display("FAIL illegal_err: got %0d pulses want 1", err_cnt - err0); end
        comp_cnt++;
        if (cv_cnt - cv0 != 1 || last_cmd !== 3'd5) begin
            mism_cnt++;
            $display("FAIL illegal_issue: got %0d strobes cmd=%0d want 1 5", cv_cnt - cv0, last_cmd);
        end
        comp_cnt++;
        if (!(err_cyc < cv_cyc)) begin
            mism_cnt++;
            $display("FAIL illegal_order: got err@%0d cv@%0d want err first", err_cyc, cv_cyc);
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 18; i++) begin
            output_valid = 1'b1;
            #1;
            comp_cnt++;
            if (frame_done !== ((i == 8 || i == 17) ? 1'b1 : 1'b0)) begin
                mism_cnt++;
                $display("FAIL frame_pulse_%0d: got %0b want %0b", i, frame_done,
                         (i == 8 || i == 17) ? 1'b1 : 1'b0);
            end
            tick();
            output_valid = 1'b0;
            tick();
        end
    endtask

`ifdef LCD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        push(3'd2);
        wait_cv(ok);
        force_busy = 1'b1;
        n = 0;
        while (n < 400 && err_timeout !== 1'b1) begin
            tick();
            n++;
        end
        comp_cnt++;
        if (err_timeout !== 1'b1 || n != 257) begin
            mism_cnt++;
            $display("FAIL timeout_flag: got %0b after %0d cycles want 1 after 257", err_timeout, n);
        end
        comp_cnt++;
        if (seq_idle !== 1'b1) begin mism_cnt++; $display("FAIL timeout_idle: got %0b want 1", seq_idle); end
        force_busy = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_stream();
        int cv0;
        bit ok;
        push(3'd1);
        wait_cv(ok);
        host_cmd   = 3'd2;
        host_valid = 1'b1;
        tick();
        tick();
        host_valid = 1'b0;
        for (int k = 2; k <= 20; k++) tick();
        comp_cnt++;
        if (datain !== 8'd30) begin mism_cnt++; $display("FAIL mid_pixel20: got %0d want 30", datain); end
        reset = 1'b1;
        tick();
        comp_cnt++;
        if (datain !== 8'd0 || cmd_valid !== 1'b0) begin
            mism_cnt++;
            $display("FAIL mid_abort: got datain=%0d cmd_valid=%0b want 0 0", datain, cmd_valid);
        end
        reset = 1'b0;
        tick();
        comp_cnt++;
        if (seq_idle !== 1'b1 || host_ready !== 1'b1) begin
            mism_cnt++;
            $display("FAIL mid_fifo_empty: got seq_idle=%0b host_ready=%0b want 1 1", seq_idle, host_ready);
        end
        cv0 = cv_cnt;
        for (int n = 0; n < 60; n++) tick();
        comp_cnt++;
        if (cv_cnt != cv0 || datain !== 8'd0) begin
            mism_cnt++;
            $display("FAIL mid_quiet: got %0d strobes datain=%0d want 0 0", cv_cnt - cv0, datain);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_fifo_full();
        test_illegal();
        test_frame();
`ifdef LCD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, mism_cnt);
        $finish;
    end

endmodule
